calc_key_fsm: RTL and testbench
===============================

Name: calc_key_fsm

Overview:
- Consumes the 4-bit key codes produced by the scancode-to-key decoder and implements two-operand calculator entry.
- Builds operand A, then an operator, then operand B, and computes the result on Enter.
- Converts the binary result to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives a 4-digit BCD bus to the seven-segment scan stage.

Parameters:
- KEY_ENTER, 4'd10, key code for Enter
- KEY_ADD, 4'd11, key code for addition
- KEY_SUB, 4'd12, key code for subtraction
- KEY_MUL, 4'd13, key code for multiplication

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- key_valid  input  1  one-cycle pulse; key_code is valid this cycle
- key_code  input  4  0-9 digit, KEY_ENTER, KEY_ADD/SUB/MUL; 14 and 15 are ignored
- disp_bcd  output  16  four BCD digits, [15:12] most significant
- neg  output  1  displayed result is negative
- busy  output  1  BCD conversion in progress
- state_dbg  output  2  current state encoding, for LEDs

Behaviour:
- Reset (async, immediate): state=S_A; operand digits, operator, digit counts, shift register and conversion counter all clear. disp_bcd=16'h0000, neg=0, busy=0, state_dbg=2'd0.
- States:
  - S_A=0: entering operand A.
  - S_B=1: entering operand B.
  - S_CONV=2: conversion.
  - S_RES=3: showing result.
- All key inputs are sampled only on a rising edge with key_valid=1. Output effects are visible after that edge (1-cycle latency).
- Operands are stored as two BCD nibbles (tens, ones) plus a digit count of 0..2.
- Digit entry: if count<2, then tens<=ones, ones<=digit, count++. If count==2, the digit is ignored, with no change.
- S_A:
  - Digit: updates A.
  - Operator key with countA>=1: latch operator, clear B, go to S_B.
  - Operator with countA==0: ignored.
  - Enter: ignored.
- S_B:
  - Digit: updates B.
  - Enter with countB>=1 goes to S_CONV.
  - Enter with countB==0: ignored.
  - Operator key: replaces the latched operator and stays in S_B.
- Entry display: in S_A, disp_bcd={8'h00,A_tens,A_ones}; in S_B, disp_bcd={8'h00,B_tens,B_ones}. neg=0 in both.
- Compute, on the Enter edge:
  - Abin=A_tens*10+A_ones and Bbin likewise (7 bits, 0..99).
  - ADD: R=A+B (max 198).
  - SUB: if A>=B then R=A-B, neg_r=0; else R=B-A, neg_r=1.
  - MUL: R=A*B (max 9801).
  - R is 14 bits, zero-extended. It loads into the double-dabble shift register; the BCD accumulator clears; count=0; busy<=1.
- S_CONV:
  - Each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1; count++.
  - After 14 shifts (14 cycles in S_CONV), go to S_RES, busy<=0, disp_bcd<=accumulator, neg<=neg_r.
  - busy is high for exactly 14 cycles.
  - disp_bcd keeps showing B during S_CONV.
  - key_valid is ignored entirely while busy=1 (keys are dropped, not queued).
- S_RES:
  - Result and neg hold.
  - Digit key: clears A/B/op, A_ones<=digit, countA=1, neg<=0, go to S_A.
  - Operator and Enter: ignored.
- Reset asserted mid-conversion or mid-entry aborts immediately to reset values. No partial result is ever displayed.
- key_valid is a single-cycle pulse by contract. Back-to-back pulses on consecutive cycles are each processed.
- Unused codes 14 and 15 cause no state or output change in any state.
- state_dbg = current state encoding.

Test Plan:
- Reset; keys 1,2,ADD,3,4,ENTER -> disp shows 0012, then 0034; busy high 14 cycles; then disp_bcd=16'h0046, neg=0, state_dbg=3.
- Keys 5,SUB,3,7,ENTER -> disp_bcd=16'h0032, neg=1. Keys 3,7,SUB,3,7,ENTER -> 16'h0000, neg=0.
- Keys 9,9,MUL,9,9,ENTER -> disp_bcd=16'h9801. Then key 4 -> disp_bcd=16'h0004, neg=0, state_dbg=0.
- Keys ADD, ENTER, 14, 15 from reset -> no change (state_dbg=0, disp 0000). Keys 1,2,3 -> disp_bcd=16'h0012 (third digit dropped). Key MUL, then ENTER with no B digit -> stays in S_B.
- Keys 2,ADD,ADD,SUB,5,ENTER -> operator replaced, result 16'h0003, neg=1. Digit pulses during busy -> ignored, result unchanged.
- Assert rst asynchronously (between clock edges) on cycle 7 of S_CONV -> outputs zero immediately, state_dbg=0, busy=0. After release, keys 8,ADD,1,ENTER -> 16'h0009.

Source files
------------

// File: rtl/calc_key_fsm.sv
// Two-operand calculator key FSM: collects A, operator, B, computes on Enter and
// converts the binary result to four BCD digits with a sequential double-dabble engine.
module calc_key_fsm #(
   parameter logic [3:0] KEY_ENTER = 4'd10,
   parameter logic [3:0] KEY_ADD   = 4'd11,
   parameter logic [3:0] KEY_SUB   = 4'd12,
   parameter logic [3:0] KEY_MUL   = 4'd13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic [15:0] disp_bcd,
   output logic        neg,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {SA = 2'd0, SB = 2'd1, SConv = 2'd2, SRes = 2'd3} state_e;
   typedef enum logic [1:0] {OpAdd = 2'd0, OpSub = 2'd1, OpMul = 2'd2} op_e;

   state_e      state_q, state_d;
   op_e         op_q, op_d;
   logic [3:0]  a_tens_q, a_tens_d, a_ones_q, a_ones_d;
   logic [3:0]  b_tens_q, b_tens_d, b_ones_q, b_ones_d;
   logic [1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic [15:0] bcd_q, bcd_d, res_q, res_d;
   logic [13:0] bin_q, bin_d;
   logic [3:0]  conv_cnt_q, conv_cnt_d;
   logic        neg_r_q, neg_r_d, neg_q, neg_d, busy_q, busy_d;

   logic        is_digit, is_op, is_enter;
   op_e         key_op;
   logic [6:0]  a_bin, b_bin;
   logic [13:0] result;
   logic        result_neg;
   logic [15:0] bcd_adj;

   assign is_digit = (key_code <= 4'd9);
   assign is_enter = (key_code == KEY_ENTER);
   assign is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB) || (key_code == KEY_MUL);

   always_comb begin
      key_op = OpAdd;
      if (key_code == KEY_SUB) key_op = OpSub;
      else if (key_code == KEY_MUL) key_op = OpMul;
   end

   assign a_bin = ({3'b000, a_tens_q} * 7'd10) + {3'b000, a_ones_q};
   assign b_bin = ({3'b000, b_tens_q} * 7'd10) + {3'b000, b_ones_q};

   always_comb begin
      result     = '0;
      result_neg = 1'b0;
      unique case (op_q)
         OpSub: begin
            if (a_bin >= b_bin) begin
               result = {7'd0, a_bin - b_bin};
            end else begin
               result     = {7'd0, b_bin - a_bin};
               result_neg = 1'b1;
            end
         end
         OpMul:   result = {7'd0, a_bin} * {7'd0, b_bin};
         default: result = {7'd0, a_bin} + {7'd0, b_bin};
      endcase
   end

   // Add-3 correction on every BCD nibble of 5 or more, ahead of the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_tens_d   = a_tens_q;
      a_ones_d   = a_ones_q;
      b_tens_d   = b_tens_q;
      b_ones_d   = b_ones_q;
      cnt_a_d    = cnt_a_q;
      cnt_b_d    = cnt_b_q;
      bcd_d      = bcd_q;
      bin_d      = bin_q;
      res_d      = res_q;
      conv_cnt_d = conv_cnt_q;
      neg_r_d    = neg_r_q;
      neg_d      = neg_q;
      busy_d     = busy_q;
      unique case (state_q)
         SA: begin
            if (key_valid) begin
               if (is_digit && cnt_a_q < 2'd2) begin
                  a_tens_d = a_ones_q;
                  a_ones_d = key_code;
                  cnt_a_d  = cnt_a_q + 2'd1;
               end else if (is_op && cnt_a_q != 2'd0) begin
                  op_d     = key_op;
                  b_tens_d = '0;
                  b_ones_d = '0;
                  cnt_b_d  = '0;
                  state_d  = SB;
               end
            end
         end
         SB: begin
            if (key_valid) begin
               if (is_digit && cnt_b_q < 2'd2) begin
                  b_tens_d = b_ones_q;
                  b_ones_d = key_code;
                  cnt_b_d  = cnt_b_q + 2'd1;
               end else if (is_op) begin
                  op_d = key_op;
               end else if (is_enter && cnt_b_q != 2'd0) begin
                  bin_d      = result;
                  bcd_d      = '0;
                  conv_cnt_d = '0;
                  neg_r_d    = result_neg;
                  busy_d     = 1'b1;
                  state_d    = SConv;
               end
            end
         end
         SConv: begin
            {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
            conv_cnt_d     = conv_cnt_q + 4'd1;
            if (conv_cnt_q == 4'd13) begin
               res_d   = {bcd_adj[14:0], bin_q[13]};
               neg_d   = neg_r_q;
               busy_d  = 1'b0;
               state_d = SRes;
            end
         end
         SRes: begin
            if (key_valid && is_digit) begin
               a_tens_d = '0;
               a_ones_d = key_code;
               cnt_a_d  = 2'd1;
               b_tens_d = '0;
               b_ones_d = '0;
               cnt_b_d  = '0;
               op_d     = OpAdd;
               neg_d    = 1'b0;
               state_d  = SA;
            end
         end
         default: state_d = SA;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= SA;
         op_q       <= OpAdd;
         a_tens_q   <= '0;
         a_ones_q   <= '0;
         b_tens_q   <= '0;
         b_ones_q   <= '0;
         cnt_a_q    <= '0;
         cnt_b_q    <= '0;
         bcd_q      <= '0;
         bin_q      <= '0;
         res_q      <= '0;
         conv_cnt_q <= '0;
         neg_r_q    <= 1'b0;
         neg_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_tens_q   <= a_tens_d;
         a_ones_q   <= a_ones_d;
         b_tens_q   <= b_tens_d;
         b_ones_q   <= b_ones_d;
         cnt_a_q    <= cnt_a_d;
         cnt_b_q    <= cnt_b_d;
         bcd_q      <= bcd_d;
         bin_q      <= bin_d;
         res_q      <= res_d;
         conv_cnt_q <= conv_cnt_d;
         neg_r_q    <= neg_r_d;
         neg_q      <= neg_d;
         busy_q     <= busy_d;
      end
   end

   // B stays on the display while converting so no partial result is ever shown.
   always_comb begin
      unique case (state_q)
         SA:      disp_bcd = {8'h00, a_tens_q, a_ones_q};
         SRes:    disp_bcd = res_q;
         default: disp_bcd = {8'h00, b_tens_q, b_ones_q};
      endcase
   end

   assign neg       = neg_q;
   assign busy      = busy_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_calc_key_fsm.sv
// Directed self-checking bench for calc_key_fsm: entry, all operators, BCD conversion,
// ignored keys, busy lockout and asynchronous reset mid-conversion.
module tb_calc_key_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic [15:0] disp_bcd;
   logic        neg;
   logic        busy;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;
   int n;

   localparam logic [3:0] ENT = 4'd10, ADD = 4'd11, SUB = 4'd12, MUL = 4'd13;

   calc_key_fsm dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .disp_bcd  (disp_bcd),
      .neg       (neg),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; one pulse spans exactly one rising edge.
   task automatic press(input logic [3:0] c);
      key_code  = c;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'd0;
   endtask

   task automatic press2(input logic [3:0] c0, input logic [3:0] c1);
      key_code  = c0;
      key_valid = 1'b1;
      @(negedge clk);
      key_code  = c1;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'd0;
   endtask

   task automatic wait_conv(output int cycles);
      cycles = 0;
      while (busy && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_disp", disp_bcd, 16'h0000);
      chk("rst_neg", {15'd0, neg}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_state", {14'd0, state_dbg}, 16'd0);
      @(negedge clk);
      rst = 1'b0;

      // 12 + 34
      press(4'd1); press(4'd2);
      chk("a_12", disp_bcd, 16'h0012);
      press(ADD);
      chk("add_state", {14'd0, state_dbg}, 16'd1);
      press(4'd3); press(4'd4);
      chk("b_34", disp_bcd, 16'h0034);
      press(ENT);
      chk("conv_busy", {15'd0, busy}, 16'd1);
      chk("conv_state", {14'd0, state_dbg}, 16'd2);
      chk("conv_disp_b", disp_bcd, 16'h0034);
      wait_conv(n);
      chk("busy_cycles", 16'(n), 16'd14);
      chk("res_46", disp_bcd, 16'h0046);
      chk("res_46_neg", {15'd0, neg}, 16'd0);
      chk("res_state", {14'd0, state_dbg}, 16'd3);

      // 5 - 37 with back-to-back digit pulses
      press(4'd5);
      chk("restart_a", disp_bcd, 16'h0005);
      chk("restart_state", {14'd0, state_dbg}, 16'd0);
      press(SUB);
      press2(4'd3, 4'd7);
      chk("b2b_37", disp_bcd, 16'h0037);
      press(ENT);
      wait_conv(n);
      chk("sub_neg_val", disp_bcd, 16'h0032);
      chk("sub_neg_flag", {15'd0, neg}, 16'd1);

      // 37 - 37
      press(4'd3);
      chk("neg_clr", {15'd0, neg}, 16'd0);
      press(4'd7); press(SUB); press(4'd3); press(4'd7); press(ENT);
      wait_conv(n);
      chk("sub_zero", disp_bcd, 16'h0000);
      chk("sub_zero_neg", {15'd0, neg}, 16'd0);

      // 99 * 99
      press(4'd9); press(4'd9); press(MUL); press(4'd9); press(4'd9); press(ENT);
      wait_conv(n);
      chk("mul_9801", disp_bcd, 16'h9801);
      press(ADD); press(ENT); press(4'd14);
      chk("res_hold", disp_bcd, 16'h9801);
      press(4'd4);
      chk("after_res_disp", disp_bcd, 16'h0004);
      chk("after_res_neg", {15'd0, neg}, 16'd0);
      chk("after_res_state", {14'd0, state_dbg}, 16'd0);

      // Ignored keys and digit overflow
      do_reset();
      press(ADD); press(ENT); press(4'd14); press(4'd15);
      chk("ign_state", {14'd0, state_dbg}, 16'd0);
      chk("ign_disp", disp_bcd, 16'h0000);
      press(4'd1); press(4'd2); press(4'd3);
      chk("third_digit", disp_bcd, 16'h0012);
      press(MUL); press(ENT);
      chk("enter_no_b", {14'd0, state_dbg}, 16'd1);
      press(4'd15);
      chk("code15_b", disp_bcd, 16'h0000);
      press(4'd3); press(ENT);
      wait_conv(n);
      chk("mul_36", disp_bcd, 16'h0036);

      // Operator replacement and keys dropped while busy
      do_reset();
      press(4'd2); press(ADD); press(ADD); press(SUB); press(4'd5); press(ENT);
      press(4'd7); press(4'd8);
      wait_conv(n);
      chk("busy_done", {15'd0, busy}, 16'd0);
      chk("opre_val", disp_bcd, 16'h0003);
      chk("opre_neg", {15'd0, neg}, 16'd1);
      chk("opre_state", {14'd0, state_dbg}, 16'd3);

      // Async reset in the seventh conversion cycle
      press(4'd9); press(MUL); press(4'd9); press(ENT);
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_disp", disp_bcd, 16'h0000);
      chk("arst_neg", {15'd0, neg}, 16'd0);
      chk("arst_busy", {15'd0, busy}, 16'd0);
      chk("arst_state", {14'd0, state_dbg}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      press(4'd8); press(ADD); press(4'd1); press(ENT);
      wait_conv(n);
      chk("post_rst_9", disp_bcd, 16'h0009);
      chk("post_rst_neg", {15'd0, neg}, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
